mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 74 +++++++
 rtl/mc_ctrl_decode.sv | 50 +++++
 rtl/mc_ctrl.sv | 143 ++++++++++++++
 tb/tb_mc_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (trap illegal opcodes into ERR).
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERR    = 3'd5
   } state_e;

   // Existing datapath ALU encoding
   localparam logic [3:0] ALU_NOP  = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_LUI  = 4'd8;
   localparam logic [3:0] ALU_NOR  = 4'd9;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;

   localparam logic [1:0] GPR_RD = 2'b00;
   localparam logic [1:0] GPR_RT = 2'b01;
   localparam logic [1:0] GPR_RA = 2'b10;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC  = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   // One-hot instruction class; jal is 'link', plain j is 'jump'
   typedef struct packed {
      logic rtype;
      logic ialu;
      logic load;
      logic store;
      logic branch;
      logic jump;
      logic link;
      logic illegal;
   } instr_cls_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class plus EXEC-state ALU controls.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0]  op_i,
   input  logic [5:0]  funct_i,
   output instr_cls_t  cls_o,
   output logic [3:0]  alu_op_o,
   output logic        alu_src_o,
   output logic        ext_op_o
);

   always_comb begin
      cls_o     = '0;
      alu_op_o  = ALU_NOP;
      alu_src_o = 1'b0;
      ext_op_o  = 1'b0;
      case (op_i)
         OP_RTYPE: begin
            cls_o.rtype = 1'b1;
            case (funct_i)
               F_ADD, F_ADDU: alu_op_o = ALU_ADD;
               F_SUB, F_SUBU: alu_op_o = ALU_SUB;
               F_AND:         alu_op_o = ALU_AND;
               F_OR:          alu_op_o = ALU_OR;
               F_NOR:         alu_op_o = ALU_NOR;
               F_SLT:         alu_op_o = ALU_SLT;
               F_SLTU:        alu_op_o = ALU_SLTU;
               F_SLL:         alu_op_o = ALU_SLL;
               default: begin
                  cls_o.rtype   = 1'b0;
                  cls_o.illegal = 1'b1;
               end
            endcase
         end
         OP_ADDI: begin cls_o.ialu = 1'b1; alu_op_o = ALU_ADD; alu_src_o = 1'b1; ext_op_o = 1'b1; end
         OP_SLTI: begin cls_o.ialu = 1'b1; alu_op_o = ALU_SLT; alu_src_o = 1'b1; ext_op_o = 1'b1; end
         OP_ANDI: begin cls_o.ialu = 1'b1; alu_op_o = ALU_AND; alu_src_o = 1'b1; end
         OP_ORI:  begin cls_o.ialu = 1'b1; alu_op_o = ALU_OR;  alu_src_o = 1'b1; end
         OP_LUI:  begin cls_o.ialu = 1'b1; alu_op_o = ALU_LUI; alu_src_o = 1'b1; end
         OP_LW:   begin cls_o.load  = 1'b1; alu_op_o = ALU_ADD; alu_src_o = 1'b1; ext_op_o = 1'b1; end
         OP_SW:   begin cls_o.store = 1'b1; alu_op_o = ALU_ADD; alu_src_o = 1'b1; ext_op_o = 1'b1; end
         OP_BEQ, OP_BNE: begin cls_o.branch = 1'b1; alu_op_o = ALU_SUB; end
         OP_J:    cls_o.jump = 1'b1;
         OP_JAL:  cls_o.link = 1'b1;
         default: cls_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing and memory handshake.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (illegal opcodes trap into sticky ERR).
module mc_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       mem_rdy,
   output logic       mem_req,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic [1:0] NPCOp,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       ALUSrc,
   output logic       EXTOp,
   output logic [3:0] ALUOp,
   output logic [1:0] GPRSel,
   output logic [1:0] WDSel,
   output logic [2:0] state,
   output logic       illegal
);

   state_e     state_q, state_d;
   instr_cls_t cls;
   logic [3:0] dec_alu_op;
   logic       dec_alu_src, dec_ext_op;

   mc_ctrl_decode u_decode (
      .op_i      (Op),
      .funct_i   (Funct),
      .cls_o     (cls),
      .alu_op_o  (dec_alu_op),
      .alu_src_o (dec_alu_src),
      .ext_op_o  (dec_ext_op)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Outputs stay zero during rst so an in-flight MEM request never commits
   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      NPCOp    = NPC_PLUS4;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      ALUSrc   = 1'b0;
      EXTOp    = 1'b0;
      ALUOp    = ALU_NOP;
      GPRSel   = GPR_RD;
      WDSel    = WD_ALU;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_rdy) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               if (cls.jump || cls.link) begin
                  PCWrite = 1'b1;
                  NPCOp   = NPC_JUMP;
                  state_d = S_FETCH;
                  if (cls.link) begin
                     RegWrite = 1'b1;
                     GPRSel   = GPR_RA;
                     WDSel    = WD_PC;
                  end
               end else if (cls.illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                  state_d = S_ERR;
`else
                  state_d = S_FETCH;
`endif
               end else begin
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               ALUOp  = dec_alu_op;
               ALUSrc = dec_alu_src;
               EXTOp  = dec_ext_op;
               if (cls.branch) begin
                  NPCOp   = NPC_BRANCH;
                  // Op[0] separates bne (0x05) from beq (0x04)
                  PCWrite = Op[0] ? ~Zero : Zero;
                  state_d = S_FETCH;
               end else if (cls.load || cls.store) begin
                  state_d = S_MEM;
               end else begin
                  state_d = S_WB;
               end
            end
            S_MEM: begin
               mem_req  = 1'b1;
               IorD     = 1'b1;
               MemWrite = cls.store;
               if (mem_rdy) state_d = cls.store ? S_FETCH : S_WB;
            end
            S_WB: begin
               RegWrite = 1'b1;
               if (cls.load) begin
                  GPRSel = GPR_RT;
                  WDSel  = WD_MEM;
               end else if (cls.ialu) begin
                  GPRSel = GPR_RT;
               end
               state_d = S_FETCH;
            end
            S_ERR: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               state_d = S_ERR;
`else
               state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   assign state = rst ? 3'd0 : state_q;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   assign illegal = !rst && (state_q == S_ERR);
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected traces built from the ISA rules.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] Op = '0, Funct = '0;
   logic       Zero = 1'b0, mem_rdy = 1'b0;
   logic       mem_req, IorD, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrc, EXTOp, illegal;
   logic [1:0] NPCOp, GPRSel, WDSel;
   logic [3:0] ALUOp;
   logic [2:0] state;

   int n_tests = 0, n_fail = 0, wr_cnt = 0;

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_rdy(mem_rdy),
      .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCOp(NPCOp),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .EXTOp(EXTOp), .ALUOp(ALUOp),
      .GPRSel(GPRSel), .WDSel(WDSel), .state(state), .illegal(illegal)
   );

   // Committed memory writes as seen by the memory side
   always @(posedge clk) if (mem_req && MemWrite && mem_rdy) wr_cnt++;

   typedef struct packed {
      logic [2:0] st;
      logic req, iord, irw, pcw;
      logic [1:0] npc;
      logic rw, mw, asrc, ext;
      logic [3:0] aop;
      logic [1:0] gsel, wsel;
      logic ill;
   } obs_t;

   typedef struct {
      obs_t o;
      logic rdy;
   } step_t;

   step_t exp_q[$];

   localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_J = 5, C_JAL = 6, C_ILL = 7;

   logic [5:0] r_functs[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h00};
   logic [5:0] other_ops[11] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

   function automatic obs_t actual();
      obs_t a;
      a = {state, mem_req, IorD, IRWrite, PCWrite, NPCOp, RegWrite, MemWrite, ALUSrc, EXTOp,
           ALUOp, GPRSel, WDSel, illegal};
      return a;
   endfunction

   function automatic obs_t blank(input logic [2:0] st);
      obs_t o = '0;
      o.st = st;
      return o;
   endfunction

   // ISA table: class and the ALU controls the instruction needs in EXEC
   function automatic int classify(input logic [5:0] op, input logic [5:0] fn,
                                   output logic [3:0] aop, output logic asrc, output logic ext);
      aop = 4'd0; asrc = 1'b0; ext = 1'b0;
      case (op)
         6'h00: case (fn)
            6'h20, 6'h21: begin aop = 4'd1; return C_R; end
            6'h22, 6'h23: begin aop = 4'd2; return C_R; end
            6'h24: begin aop = 4'd3; return C_R; end
            6'h25: begin aop = 4'd4; return C_R; end
            6'h2A: begin aop = 4'd5; return C_R; end
            6'h2B: begin aop = 4'd6; return C_R; end
            6'h00: begin aop = 4'd7; return C_R; end
            6'h27: begin aop = 4'd9; return C_R; end
            default: return C_ILL;
         endcase
         6'h08: begin aop = 4'd1; asrc = 1; ext = 1; return C_I; end
         6'h0A: begin aop = 4'd5; asrc = 1; ext = 1; return C_I; end
         6'h0C: begin aop = 4'd3; asrc = 1; return C_I; end
         6'h0D: begin aop = 4'd4; asrc = 1; return C_I; end
         6'h0F: begin aop = 4'd8; asrc = 1; return C_I; end
         6'h23: begin aop = 4'd1; asrc = 1; ext = 1; return C_LW; end
         6'h2B: begin aop = 4'd1; asrc = 1; ext = 1; return C_SW; end
         6'h04, 6'h05: begin aop = 4'd2; return C_BR; end
         6'h02: return C_J;
         6'h03: return C_JAL;
         default: return C_ILL;
      endcase
   endfunction

   function automatic void push(input obs_t o, input logic rdy);
      step_t s;
      s.o = o; s.rdy = rdy;
      exp_q.push_back(s);
   endfunction

   // Expected cycle-by-cycle trace; wf/wm = mem_rdy-low cycles in FETCH/MEM
   function automatic int build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input int wf, input int wm);
      obs_t o;
      logic [3:0] aop;
      logic asrc, ext;
      int c;
      c = classify(op, fn, aop, asrc, ext);
      exp_q.delete();
      o = blank(3'd0); o.req = 1;
      for (int i = 0; i < wf; i++) push(o, 1'b0);
      o.irw = 1; o.pcw = 1; o.npc = 2'b00;
      push(o, 1'b1);
      o = blank(3'd1);
      if (c == C_J || c == C_JAL) begin
         o.pcw = 1; o.npc = 2'b10;
         if (c == C_JAL) begin o.rw = 1; o.gsel = 2'b10; o.wsel = 2'b10; end
         push(o, 1'($urandom));
         return c;
      end
      push(o, 1'($urandom));
      if (c == C_ILL) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         o = blank(3'd5); o.ill = 1;
         for (int i = 0; i < 4; i++) push(o, 1'($urandom));
`endif
         return c;
      end
      o = blank(3'd2); o.aop = aop; o.asrc = asrc; o.ext = ext;
      if (c == C_BR) begin
         o.npc = 2'b01;
         o.pcw = (op == 6'h04) ? z : ~z;
      end
      push(o, 1'($urandom));
      if (c == C_BR) return c;
      if (c == C_LW || c == C_SW) begin
         o = blank(3'd3); o.req = 1; o.iord = 1; o.mw = (c == C_SW);
         for (int i = 0; i < wm; i++) push(o, 1'b0);
         push(o, 1'b1);
         if (c == C_SW) return c;
      end
      o = blank(3'd4); o.rw = 1;
      if (c == C_I)  o.gsel = 2'b01;
      if (c == C_LW) begin o.gsel = 2'b01; o.wsel = 2'b01; end
      push(o, 1'($urandom));
      return c;
   endfunction

   // Replays the queued trace; called at posedge+1 with the DUT in FETCH
   task automatic replay(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int keep);
      int n;
      n = exp_q.size() - keep;
      Op = op; Funct = fn; Zero = z;
      for (int i = 0; i < n; i++) begin
         mem_rdy = exp_q[i].rdy;
         @(negedge clk);
         n_tests++;
         if (actual() !== exp_q[i].o) begin
            n_fail++;
            $display("FAIL %s op=%h fn=%h cyc=%0d: got %h expected %h", name, op, fn, i,
                     actual(), exp_q[i].o);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int wf, input int wm);
      int c, w0;
      w0 = wr_cnt;
      c = build(op, fn, z, wf, wm);
      replay(name, op, fn, z, 0);
      n_tests++;
      if (wr_cnt !== w0 + ((c == C_SW) ? 1 : 0)) begin
         n_fail++;
         $display("FAIL %s_writes op=%h: got %0d expected %0d", name, op, wr_cnt - w0,
                  (c == C_SW) ? 1 : 0);
      end
   endtask

   task automatic test_reset();
      rst = 1; Op = 6'h23; Funct = 6'h20; Zero = 1; mem_rdy = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (actual() !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected 0", actual());
      end
      @(posedge clk); #1;
      rst = 0; mem_rdy = 0;
      @(negedge clk);
      n_tests++;
      if (actual() !== 22'(obs_t'({3'd0, 1'b1, 18'd0}))) begin
         n_fail++; $display("FAIL reset_exit: got %h expected FETCH with mem_req", actual());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
   endtask

   task automatic test_lw_wait();
      run_instr("lw_wait", 6'h23, 6'h00, 1'b0, 0, 2);
   endtask

   task automatic test_branch();
      run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0);
      run_instr("beq_not",   6'h04, 6'h00, 1'b0, 0, 0);
      run_instr("bne_taken", 6'h05, 6'h00, 1'b0, 0, 0);
      run_instr("bne_not",   6'h05, 6'h00, 1'b1, 1, 0);
   endtask

   task automatic test_jal();
      run_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0);
      run_instr("j",   6'h02, 6'h00, 1'b1, 2, 0);
   endtask

   task automatic test_sw_reset();
      int w0, c;
      w0 = wr_cnt;
      c = build(6'h2B, 6'h00, 1'b0, 0, 2);
      replay("sw_rst", 6'h2B, 6'h00, 1'b0, 1);
      rst = 1; mem_rdy = 1;
      @(negedge clk);
      n_tests++;
      if (actual() !== '0) begin
         n_fail++; $display("FAIL sw_rst_outputs: got %h expected 0", actual());
      end
      @(posedge clk); #1;
      rst = 0; mem_rdy = 0;
      @(negedge clk);
      n_tests++;
      if (state !== 3'd0 || mem_req !== 1'b1) begin
         n_fail++; $display("FAIL sw_rst_restart: got state=%0d req=%b expected 0/1", state, mem_req);
      end
      n_tests++;
      if (wr_cnt !== w0 || c != C_SW) begin
         n_fail++; $display("FAIL sw_rst_nowrite: got %0d writes expected 0", wr_cnt - w0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [5:0] op, fn;
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            op = 6'h00; fn = r_functs[$urandom_range(0, 9)];
         end else begin
            op = other_ops[$urandom_range(0, 10)]; fn = 6'($urandom);
         end
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
         if ($urandom_range(0, 9) == 0) begin
            op = 6'h00; fn = 6'h01;
         end
`endif
         run_instr("random", op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask

   task automatic test_illegal();
      run_instr("illegal", 6'h3F, 6'h00, 1'b0, 1, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
`endif
      run_instr("after_illegal", 6'h0D, 6'h00, 1'b0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_branch();
      test_jal();
      test_sw_reset();
      test_random();
      test_illegal();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
